// File: rtl/lsu_mem_if.sv
// Load/store unit bridging the datapath to a ready-handshake data memory.
// Handles byte-lane steering for stores, load extension, Stall generation and access timeout.
module lsu_mem_if #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisalignErr,
   output logic        TimeoutErr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [31:0]       read_data_q, read_data_d;
   logic              misalign_q, misalign_d;
   logic              timeout_q, timeout_d;

   logic              access;
   logic              is_store;
   logic              access_legal;

   // Stores only accept B/H/W; loads additionally accept BU/HU.
   function automatic logic legal_access(input logic store, input logic [2:0] f3,
                                         input logic [1:0] a);
      logic ok;
      ok = 1'b0;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b001:  ok = ~a[0];
         3'b010:  ok = (a == 2'b00);
         3'b100:  ok = ~store;
         3'b101:  ok = ~store & ~a[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] lane_be(input logic store, input logic [2:0] f3,
                                          input logic [1:0] a);
      logic [3:0] be;
      be = 4'b1111;
      if (store) begin
         case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
         endcase
      end
      return be;
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] d;
      case (f3[1:0])
         2'b00:   d = {4{wd[7:0]}};
         2'b01:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
      logic [31:0] s;
      logic [31:0] r;
      s = w >> {a, 3'b000};
      case (f3)
         3'b000:  r = {{24{s[7]}}, s[7:0]};
         3'b001:  r = {{16{s[15]}}, s[15:0]};
         3'b100:  r = {24'd0, s[7:0]};
         3'b101:  r = {16'd0, s[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   assign access       = MemRead | MemWrite;
   assign is_store     = MemWrite;
   assign access_legal = legal_access(is_store, Funct3, ALUResult[1:0]);

   // The launch cycle stalls combinationally so the PC never advances past a pending access.
   assign Stall = reset & ((state_q == BUSY) ||
                           ((state_q == IDLE) && access && access_legal));

   always_comb begin
      // NOTE: every _d starts from its _q so no path through the case leaves a signal
      // unassigned; a missing default here would infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      read_data_d = read_data_q;
      misalign_d  = misalign_q;
      timeout_d   = timeout_q;

      unique case (state_q)
         IDLE: begin
            if (access) begin
               if (access_legal) begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_addr_d  = {ALUResult[31:2], 2'b00};
                  mem_wdata_d = lane_wdata(Funct3, WriteData);
                  mem_be_d    = lane_be(is_store, Funct3, ALUResult[1:0]);
                  funct3_d    = Funct3;
                  addr_lo_d   = ALUResult[1:0];
                  cnt_d       = '0;
                  state_d     = BUSY;
               end else begin
                  misalign_d = 1'b1;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (mem_ready) begin
               if (!mem_we_q) begin
                  read_data_d = load_extend(funct3_q, addr_lo_q, mem_rdata);
               end
               mem_req_d = 1'b0;
               state_d   = DONE;
            end else if (cnt_q == CNT_LAST) begin
               mem_req_d   = 1'b0;
               read_data_d = '0;
               timeout_d   = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   // NOTE: state updates use <= so every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         funct3_q    <= '0;
         addr_lo_q   <= '0;
         read_data_q <= '0;
         misalign_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         read_data_q <= read_data_d;
         misalign_q  <= misalign_d;
         timeout_q   <= timeout_d;
      end
   end

   assign ReadData    = read_data_q;
   assign MisalignErr = misalign_q;
   assign TimeoutErr  = timeout_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_be      = mem_be_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: directed corner cases followed by random accesses
// checked against an arithmetic reference model of the load/store rules.
module tb_lsu_mem_if;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [2:0]  Funct3 = '0;
   logic [31:0] ALUResult = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        Stall;
   logic        MisalignErr;
   logic        TimeoutErr;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd_exp       = '0;
   logic        misalign_exp = 1'b0;
   logic        timeout_exp  = 1'b0;

   lsu_mem_if #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Funct3     (Funct3),
      .ALUResult  (ALUResult),
      .WriteData  (WriteData),
      .ReadData   (ReadData),
      .Stall      (Stall),
      .MisalignErr(MisalignErr),
      .TimeoutErr (TimeoutErr),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_legal(input logic store, input logic [2:0] f3,
                                        input logic [31:0] addr);
      int a;
      a = int'(addr % 4);
      if (store) return (f3 == 0) || (f3 == 1 && a % 2 == 0) || (f3 == 2 && a == 0);
      return (f3 == 0 || f3 == 4) || ((f3 == 1 || f3 == 5) && a % 2 == 0) || (f3 == 2 && a == 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdat);
      int     sh;
      longint v;
      sh = 8 * int'(addr % 4);
      case (f3)
         3'd0, 3'd4: begin
            v = longint'((rdat >> sh) & 32'hFF);
            if (f3 == 3'd0 && v >= 128) v -= 256;
         end
         3'd1, 3'd5: begin
            v = longint'((rdat >> sh) & 32'hFFFF);
            if (f3 == 3'd1 && v >= 32768) v -= 65536;
         end
         default: v = longint'(rdat);
      endcase
      return 32'(v);
   endfunction

   // Starts at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
   // ready_at = k delivers mem_ready on the k-th BUSY cycle; 0 means never.
   task automatic do_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdat, input int ready_at);
      logic        store, legal, hit;
      logic [31:0] exp_addr, exp_wdata;
      logic [3:0]  exp_be;
      int          a, busy_cycles, stall_cnt;
      store = wr;
      a     = int'(addr % 4);
      legal = model_legal(store, f3, addr);
      MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
      mem_ready = 1'b0;
      stall_cnt = 0;
      @(negedge clk);
      if (Stall === 1'b1) stall_cnt++;
      check({tag, "_stall_launch"}, {31'd0, Stall}, {31'd0, legal});
      check({tag, "_req_launch"}, {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      if (!legal) begin
         misalign_exp = 1'b1;
         MemRead = 1'b0; MemWrite = 1'b0;
         @(negedge clk);
         check({tag, "_misalign"}, {31'd0, MisalignErr}, {31'd0, misalign_exp});
         check({tag, "_req_none"}, {31'd0, mem_req}, 32'd0);
         check({tag, "_stall_none"}, {31'd0, Stall}, 32'd0);
         @(posedge clk); #1;
         return;
      end
      exp_addr = addr & 32'hFFFF_FFFC;
      if (!store)        exp_be = 4'hF;
      else if (f3 == 0)  exp_be = 4'(1 << a);
      else if (f3 == 1)  exp_be = 4'(3 << a);
      else               exp_be = 4'hF;
      if (f3 == 0)       exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
      else if (f3 == 1)  exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      else               exp_wdata = wd;
      hit = (ready_at >= 1 && ready_at <= TIMEOUT);
      busy_cycles = hit ? ready_at : TIMEOUT;
      for (int k = 1; k <= busy_cycles; k++) begin
         mem_ready = (k == ready_at);
         mem_rdata = (k == ready_at) ? rdat : $urandom;
         @(negedge clk);
         if (Stall === 1'b1) stall_cnt++;
         check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
         check({tag, "_we"}, {31'd0, mem_we}, {31'd0, store});
         check({tag, "_addr"}, mem_addr, exp_addr);
         check({tag, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
         if (store) check({tag, "_wdata"}, mem_wdata, exp_wdata);
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      if (!hit) begin
         rd_exp = '0;
         timeout_exp = 1'b1;
      end else if (!store) begin
         rd_exp = model_load(f3, addr, rdat);
      end
      // Inputs stay asserted in DONE: the unit must not stall or re-launch there.
      @(negedge clk);
      check({tag, "_stall_done"}, {31'd0, Stall}, 32'd0);
      check({tag, "_req_done"}, {31'd0, mem_req}, 32'd0);
      check({tag, "_rdata"}, ReadData, rd_exp);
      check({tag, "_timeout"}, {31'd0, TimeoutErr}, {31'd0, timeout_exp});
      check({tag, "_misalign_hold"}, {31'd0, MisalignErr}, {31'd0, misalign_exp});
      check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(busy_cycles + 1));
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rdata"}, ReadData, 32'd0);
      check({tag, "_stall"}, {31'd0, Stall}, 32'd0);
      check({tag, "_misalign"}, {31'd0, MisalignErr}, 32'd0);
      check({tag, "_timeout"}, {31'd0, TimeoutErr}, 32'd0);
      check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
      check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
      check({tag, "_addr"}, mem_addr, 32'd0);
      check({tag, "_wdata"}, mem_wdata, 32'd0);
      check({tag, "_be"}, {28'd0, mem_be}, 32'd0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] addr;
      logic        wr;
      int          ready_at;
      logic [31:0] keep;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      // SW, ready on 2nd BUSY cycle: three stall cycles.
      do_access("sw", 1'b0, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, '0, 2);
      // Signed and unsigned byte loads from the top lane.
      do_access("lb", 1'b1, 1'b0, 3'd0, 32'h103, '0, 32'h80FF_1234, 1);
      do_access("lbu", 1'b1, 1'b0, 3'd4, 32'h103, '0, 32'h80FF_1234, 3);
      // Upper-half store and signed halfword load.
      do_access("sh", 1'b0, 1'b1, 3'd1, 32'h102, 32'h0000_ABCD, '0, 1);
      do_access("lh", 1'b1, 1'b0, 3'd1, 32'h102, '0, 32'h8001_0000, 2);
      // A store leaves ReadData unchanged; both-high counts as a store.
      do_access("sb_both", 1'b1, 1'b1, 3'd0, 32'h201, 32'h0000_005A, 32'h1111_1111, 1);
      // Misaligned word load is refused and flagged.
      do_access("lw_mis", 1'b1, 1'b0, 3'd2, 32'h101, '0, '0, 1);
      @(negedge clk);
      check("mis_sticky", {31'd0, MisalignErr}, 32'd1);
      @(posedge clk); #1;
      // Illegal Funct3 on a store.
      do_access("sbu_ill", 1'b0, 1'b1, 3'd4, 32'h300, 32'h1, '0, 1);

      // mem_ready while idle has no effect.
      keep = rd_exp;
      mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      check("idle_ready_stall", {31'd0, Stall}, 32'd0);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      check("idle_ready_rdata", ReadData, keep);
      check("idle_ready_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;

      // Load that never gets ready: aborted after TIMEOUT busy cycles.
      do_access("lw_to", 1'b1, 1'b0, 3'd2, 32'h400, '0, '0, 0);
      // Ready exactly on the last allowed cycle still completes.
      do_access("lw_last", 1'b1, 1'b0, 3'd2, 32'h404, '0, 32'h1234_5678, TIMEOUT);

      // Reset during BUSY abandons the access and clears everything.
      MemRead = 1'b1; Funct3 = 3'd2; ALUResult = 32'h200; mem_ready = 1'b0;
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; MemRead = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_all_zero("rst_busy");
      @(posedge clk); #1;
      reset = 1'b1;
      rd_exp = '0; misalign_exp = 1'b0; timeout_exp = 1'b0;
      do_access("lw_after_rst", 1'b1, 1'b0, 3'd2, 32'h204, '0, 32'h0BAD_F00D, 2);

      // Random mix of loads and stores.
      for (int i = 0; i < 40; i++) begin
         wr = ($urandom_range(0, 9) < 4);
         if (wr) f3 = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         else begin
            case ($urandom_range(0, 5))
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd4;
               4: f3 = 3'd5;
               default: f3 = 3'($urandom_range(6, 7));
            endcase
         end
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[0] = 1'b0;
         if ($urandom_range(0, 1) == 1) addr[1] = 1'b0;
         ready_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
         do_access("rnd", ~wr, wr, f3, addr, $urandom, $urandom, ready_at);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
